// File: rtl/bsk_mgr_common_param_pkg.sv
// Shared BSK manager storage parameters, derived widths and write-dispatch state type.
// Revision: 1.0
`default_nettype none

package bsk_mgr_common_param_pkg;

  localparam int BSK_CUT_NB   = 16;
  localparam int CUT_W        = 64;
  localparam int WORD_PER_CUT = 32;
  localparam int SLOT_NB      = 8;

  localparam int SLOT_W    = $clog2(SLOT_NB);
  localparam int CUT_ADD_W = $clog2(SLOT_NB * WORD_PER_CUT);
  localparam int CUT_ID_W  = $clog2(BSK_CUT_NB);
  localparam int WORD_ID_W = $clog2(WORD_PER_CUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } wr_state_e;

endpackage

`default_nettype wire

// File: rtl/bsk_mgr_cut_wr_cnt.sv
// Cut/word counter pair: cut index advances per word, word index advances on cut wrap.
// Revision: 1.0
`default_nettype none

module bsk_mgr_cut_wr_cnt #(
  parameter int CUT_NB  = 16,
  parameter int WORD_NB = 32
) (
  input  logic                       clk,
  input  logic                       a_rst,
  input  logic                       clr,
  input  logic                       inc,
  output logic [$clog2(CUT_NB)-1:0]  cut_cnt,
  output logic [$clog2(WORD_NB)-1:0] word_cnt,
  output logic                       last
);

  localparam int CID_W = $clog2(CUT_NB);
  localparam int WID_W = $clog2(WORD_NB);

  localparam logic [CID_W-1:0] CUT_MAX  = CID_W'(CUT_NB - 1);
  localparam logic [WID_W-1:0] WORD_MAX = WID_W'(WORD_NB - 1);

  logic cut_wrap;

  assign cut_wrap = (cut_cnt == CUT_MAX);
  assign last     = cut_wrap && (word_cnt == WORD_MAX);

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      cut_cnt  <= '0;
      word_cnt <= '0;
    end else if (clr) begin
      cut_cnt  <= '0;
      word_cnt <= '0;
    end else if (inc) begin
      if (cut_wrap) begin
        cut_cnt  <= '0;
        word_cnt <= word_cnt + 1'b1;
      end else begin
        cut_cnt <= cut_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bsk_mgr_cut_wr_dispatch.sv
// BSK storage write front end: spreads a slot's word stream round-robin over the RAM cuts.
// Revision: 1.0
`default_nettype none

module bsk_mgr_cut_wr_dispatch #(
  parameter int BSK_CUT_NB   = bsk_mgr_common_param_pkg::BSK_CUT_NB,
  parameter int CUT_W        = bsk_mgr_common_param_pkg::CUT_W,
  parameter int WORD_PER_CUT = bsk_mgr_common_param_pkg::WORD_PER_CUT,
  parameter int SLOT_NB      = bsk_mgr_common_param_pkg::SLOT_NB
) (
  input  logic                                    clk,
  input  logic                                    a_rst,
  input  logic                                    cmd_vld,
  output logic                                    cmd_rdy,
  input  logic [$clog2(SLOT_NB)-1:0]              cmd_slot,
  input  logic                                    in_vld,
  output logic                                    in_rdy,
  input  logic [CUT_W-1:0]                        in_data,
  input  logic [SLOT_NB-1:0]                      slot_rd_lock,
  output logic [BSK_CUT_NB-1:0]                   wr_en,
  output logic [$clog2(SLOT_NB*WORD_PER_CUT)-1:0] wr_add,
  output logic [CUT_W-1:0]                        wr_data,
  output logic                                    done_vld,
  output logic [$clog2(SLOT_NB)-1:0]              done_slot,
  output logic                                    busy
);

  import bsk_mgr_common_param_pkg::*;

  localparam int SLOT_BITS = $clog2(SLOT_NB);
  localparam int ID_BITS   = $clog2(BSK_CUT_NB);
  localparam int WORD_BITS = $clog2(WORD_PER_CUT);

  wr_state_e state, state_nxt;

  logic [SLOT_BITS-1:0]  slot_q;
  logic [ID_BITS-1:0]    cut_cnt;
  logic [WORD_BITS-1:0]  word_cnt;
  logic                  last_word;
  logic                  cmd_acc;
  logic                  in_hs;
  logic [BSK_CUT_NB-1:0] cut_onehot;

  // Gated by reset so the command port never looks ready while held in reset.
  assign cmd_rdy = (state == ST_IDLE) && !slot_rd_lock[cmd_slot] && !a_rst;
  assign in_rdy  = (state == ST_LOAD);
  assign cmd_acc = cmd_vld && cmd_rdy;
  assign in_hs   = in_vld && in_rdy;

  assign busy      = (state != ST_IDLE);
  assign done_vld  = (state == ST_DONE);
  assign done_slot = done_vld ? slot_q : '0;

  bsk_mgr_cut_wr_cnt #(
    .CUT_NB  (BSK_CUT_NB),
    .WORD_NB (WORD_PER_CUT)
  ) u_cnt (
    .clk      (clk),
    .a_rst    (a_rst),
    .clr      (cmd_acc),
    .inc      (in_hs),
    .cut_cnt  (cut_cnt),
    .word_cnt (word_cnt),
    .last     (last_word)
  );

  always_comb begin
    cut_onehot          = '0;
    cut_onehot[cut_cnt] = 1'b1;
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (cmd_acc) state_nxt = ST_LOAD;
      ST_LOAD: if (in_hs && last_word) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      slot_q <= '0;
    end else if (cmd_acc) begin
      slot_q <= cmd_slot;
    end
  end

  // Slot base address is slot*WORD_PER_CUT; power-of-two sizing makes it a concatenation.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      wr_en   <= '0;
      wr_add  <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= in_hs ? cut_onehot : '0;
      if (in_hs) begin
        wr_add  <= {slot_q, word_cnt};
        wr_data <= in_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bsk_mgr_cut_wr_dispatch.sv
// Directed bench for bsk_mgr_cut_wr_dispatch: loads, lock stall, gaps, queued command, reset mid-load.
`default_nettype none

module tb_bsk_mgr_cut_wr_dispatch;

  logic        clk;
  logic        a_rst;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic [2:0]  cmd_slot;
  logic        in_vld;
  logic        in_rdy;
  logic [63:0] in_data;
  logic [7:0]  slot_rd_lock;
  logic [15:0] wr_en;
  logic [7:0]  wr_add;
  logic [63:0] wr_data;
  logic        done_vld;
  logic [2:0]  done_slot;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] hits [0:255];

  bsk_mgr_cut_wr_dispatch dut (
    .clk          (clk),
    .a_rst        (a_rst),
    .cmd_vld      (cmd_vld),
    .cmd_rdy      (cmd_rdy),
    .cmd_slot     (cmd_slot),
    .in_vld       (in_vld),
    .in_rdy       (in_rdy),
    .in_data      (in_data),
    .slot_rd_lock (slot_rd_lock),
    .wr_en        (wr_en),
    .wr_add       (wr_add),
    .wr_data      (wr_data),
    .done_vld     (done_vld),
    .done_slot    (done_slot),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents a command at #1 after an edge and expects acceptance on the next edge.
  task automatic accept_cmd(input int slot);
    cmd_slot = 3'(slot);
    cmd_vld  = 1'b1;
    #1;
    n_checks++; if (cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL accept_rdy slot %0d: got %b expected 1", slot, cmd_rdy); end
    @(posedge clk); #1;
    cmd_vld = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL accept_busy slot %0d: got %b expected 1", slot, busy); end
    n_checks++; if (wr_en !== 16'h0) begin n_fail++; $display("FAIL accept_wr_en slot %0d: got %h expected 0000", slot, wr_en); end
  endtask

  // Streams 512 words into a slot already in LOAD and checks every write cycle.
  task automatic feed_slot(input int slot, input bit gaps);
    int          k;
    int          cyc;
    int          writes;
    bit          hs;
    logic [15:0] exp_en;
    logic [7:0]  exp_add;
    logic [63:0] exp_data;
    k = 0; cyc = 0; writes = 0;
    for (int a = 0; a < 256; a++) hits[a] = 16'h0;
    while (k < 512 && cyc < 4000) begin
      hs      = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      in_vld  = hs;
      in_data = {32'(slot), 32'(k)};
      n_checks++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL in_rdy slot %0d word %0d: got %b expected 1", slot, k, in_rdy); end
      @(posedge clk); #1;
      cyc++;
      n_checks++; if (cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL cmd_rdy_busy slot %0d: got %b expected 0", slot, cmd_rdy); end
      if (hs) begin
        exp_en   = 16'(1 << (k % 16));
        exp_add  = 8'(slot * 32 + k / 16);
        exp_data = {32'(slot), 32'(k)};
        n_checks++; if (wr_en !== exp_en) begin n_fail++; $display("FAIL wr_en slot %0d word %0d: got %h expected %h", slot, k, wr_en, exp_en); end
        n_checks++; if (wr_add !== exp_add) begin n_fail++; $display("FAIL wr_add slot %0d word %0d: got %0d expected %0d", slot, k, wr_add, exp_add); end
        n_checks++; if (wr_data !== exp_data) begin n_fail++; $display("FAIL wr_data slot %0d word %0d: got %h expected %h", slot, k, wr_data, exp_data); end
        if (k == 511) begin
          n_checks++; if (done_vld !== 1'b1) begin n_fail++; $display("FAIL done_vld slot %0d: got %b expected 1", slot, done_vld); end
          n_checks++; if (done_slot !== 3'(slot)) begin n_fail++; $display("FAIL done_slot: got %0d expected %0d", done_slot, slot); end
        end else begin
          n_checks++; if (done_vld !== 1'b0) begin n_fail++; $display("FAIL early_done slot %0d word %0d: got %b expected 0", slot, k, done_vld); end
        end
        k++;
      end else begin
        n_checks++; if (wr_en !== 16'h0) begin n_fail++; $display("FAIL gap_wr_en slot %0d: got %h expected 0000", slot, wr_en); end
        n_checks++; if (done_vld !== 1'b0) begin n_fail++; $display("FAIL gap_done slot %0d: got %b expected 0", slot, done_vld); end
      end
      if (wr_en !== 16'h0) begin
        writes++;
        n_checks++; if ((hits[wr_add] & wr_en) !== 16'h0) begin n_fail++; $display("FAIL dup_write addr %0d: got en %h with hits %h expected no overlap", wr_add, wr_en, hits[wr_add]); end
        hits[wr_add] = hits[wr_add] | wr_en;
      end
      in_vld = 1'b0;
    end
    n_checks++; if (k != 512) begin n_fail++; $display("FAIL feed_timeout slot %0d: got %0d words expected 512", slot, k); end
    n_checks++; if (writes != 512) begin n_fail++; $display("FAIL write_count slot %0d: got %0d expected 512", slot, writes); end
    for (int w = 0; w < 32; w++) begin
      n_checks++; if (hits[slot * 32 + w] !== 16'hFFFF) begin n_fail++; $display("FAIL coverage addr %0d: got %h expected ffff", slot * 32 + w, hits[slot * 32 + w]); end
    end
  endtask

  task automatic check_idle(input string tag);
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy: got %b expected 0", tag, busy); end
    n_checks++; if (wr_en !== 16'h0) begin n_fail++; $display("FAIL %s_wr_en: got %h expected 0000", tag, wr_en); end
    n_checks++; if (done_vld !== 1'b0) begin n_fail++; $display("FAIL %s_done: got %b expected 0", tag, done_vld); end
    n_checks++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL %s_in_rdy: got %b expected 0", tag, in_rdy); end
  endtask

  task automatic test_reset();
    a_rst = 1'b1; cmd_vld = 1'b1; cmd_slot = 3'd0; in_vld = 1'b1; in_data = 64'hFFFF;
    slot_rd_lock = 8'h00;
    #2;
    n_checks++; if (cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_rdy: got %b expected 0", cmd_rdy); end
    n_checks++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_in_rdy: got %b expected 0", in_rdy); end
    n_checks++; if (wr_en !== 16'h0) begin n_fail++; $display("FAIL rst_wr_en: got %h expected 0000", wr_en); end
    n_checks++; if (wr_add !== 8'h0) begin n_fail++; $display("FAIL rst_wr_add: got %h expected 00", wr_add); end
    n_checks++; if (wr_data !== 64'h0) begin n_fail++; $display("FAIL rst_wr_data: got %h expected 0", wr_data); end
    n_checks++; if ({done_vld, done_slot, busy} !== 5'b0) begin n_fail++; $display("FAIL rst_done_busy: got %b expected 00000", {done_vld, done_slot, busy}); end
    cmd_vld = 1'b0; in_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1 a_rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL post_rst_cmd_rdy: got %b expected 1", cmd_rdy); end
  endtask

  task automatic test_basic_load();
    accept_cmd(3);
    feed_slot(3, 1'b0);
    check_idle("basic_end");
  endtask

  task automatic test_lock();
    slot_rd_lock = 8'h04;
    cmd_slot     = 3'd2;
    cmd_vld      = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      n_checks++; if (cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL lock_cmd_rdy cycle %0d: got %b expected 0", c, cmd_rdy); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL lock_busy cycle %0d: got %b expected 0", c, busy); end
    end
    slot_rd_lock = 8'h00;
    accept_cmd(2);
    slot_rd_lock = 8'h04;
    feed_slot(2, 1'b0);
    slot_rd_lock = 8'h00;
    check_idle("lock_end");
  endtask

  task automatic test_gaps();
    accept_cmd(7);
    feed_slot(7, 1'b1);
    check_idle("gap_end");
  endtask

  task automatic test_back_to_back();
    accept_cmd(0);
    cmd_slot = 3'd5;
    cmd_vld  = 1'b1;
    feed_slot(0, 1'b0);
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_busy: got %b expected 0", busy); end
    n_checks++; if (cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_rdy: got %b expected 1", cmd_rdy); end
    @(posedge clk); #1;
    cmd_vld = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_second_busy: got %b expected 1", busy); end
    feed_slot(5, 1'b0);
    check_idle("b2b_end");
  endtask

  task automatic test_reset_mid_load();
    accept_cmd(4);
    for (int k = 0; k < 100; k++) begin
      in_vld  = 1'b1;
      in_data = 64'(k);
      @(posedge clk); #1;
    end
    in_vld = 1'b0;
    n_checks++; if (wr_en !== 16'h0008) begin n_fail++; $display("FAIL mid_wr_en: got %h expected 0008", wr_en); end
    n_checks++; if (wr_add !== 8'd134) begin n_fail++; $display("FAIL mid_wr_add: got %0d expected 134", wr_add); end
    #2 a_rst = 1'b1;
    #1;
    n_checks++; if (wr_en !== 16'h0) begin n_fail++; $display("FAIL arst_wr_en: got %h expected 0000", wr_en); end
    n_checks++; if (wr_add !== 8'h0) begin n_fail++; $display("FAIL arst_wr_add: got %0d expected 0", wr_add); end
    n_checks++; if (wr_data !== 64'h0) begin n_fail++; $display("FAIL arst_wr_data: got %h expected 0", wr_data); end
    n_checks++; if ({busy, in_rdy, cmd_rdy, done_vld} !== 4'b0) begin n_fail++; $display("FAIL arst_ctrl: got %b expected 0000", {busy, in_rdy, cmd_rdy, done_vld}); end
    @(posedge clk);
    @(posedge clk);
    #1 a_rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      n_checks++; if (done_vld !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL post_arst_done cycle %0d: got done %b busy %b expected 0 0", c, done_vld, busy); end
    end
    accept_cmd(4);
    feed_slot(4, 1'b0);
    check_idle("rst_end");
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_lock();
    test_gaps();
    test_back_to_back();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
